// File: rtl/vga_pixel_scanner.sv
// Raster scan generator for the pixel-coordinate interface: counters, frame strobe,
// and sync/blank delayed to line up with the colour coming back from the drawers.
module vga_pixel_scanner #(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned H_FP           = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BP           = 48,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_FP           = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BP           = 33,
  parameter int unsigned SYNC_ACTIVE_HI = 0,
  parameter int unsigned PIPE_DELAY     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_en,
  input  logic [7:0]         rgb_in,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               startOfFrame,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic [7:0]         rgb_out,
  output logic [15:0]        frame_count
);

  localparam int unsigned CW = 11;

  localparam logic [CW-1:0] HActive  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HSyncBeg = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncEnd = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] HLast    = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] VActive  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VSyncBeg = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncEnd = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] VLast    = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // XOR mask that maps a raw "in sync" bit onto the pin polarity.
  localparam logic SyncInv = (SYNC_ACTIVE_HI == 0);

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          x_wrap, frame_wrap;
  logic          act_raw, hs_raw, vs_raw;
  logic          act_dly, hs_dly, vs_dly;

  // Each stage holds {act, hs, vs} for one pixel.
  logic [PIPE_DELAY-1:0][2:0] dly_q;

  logic        sof_q;
  logic [15:0] frame_q;
  logic        hsync_q, vsync_q, blank_q;
  logic [7:0]  rgb_q;

  always_comb begin
    x_wrap     = (x_q == HLast);
    frame_wrap = x_wrap && (y_q == VLast);
    x_d        = x_wrap ? '0 : x_q + CW'(1);
    y_d        = y_q;
    if (x_wrap) begin
      y_d = (y_q == VLast) ? '0 : y_q + CW'(1);
    end
  end

  always_comb begin
    act_raw = (x_q < HActive) && (y_q < VActive);
    hs_raw  = (x_q >= HSyncBeg) && (x_q < HSyncEnd);
    vs_raw  = (y_q >= VSyncBeg) && (y_q < VSyncEnd);
    {act_dly, hs_dly, vs_dly} = dly_q[PIPE_DELAY-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
      frame_q <= '0;
      dly_q   <= '0;
      blank_q <= 1'b0;
      hsync_q <= SyncInv;
      vsync_q <= SyncInv;
      rgb_q   <= '0;
    end else begin
      // Strobe is a single clk wide even when pixel_en is sparse.
      sof_q <= 1'b0;
      if (pixel_en) begin
        x_q <= x_d;
        y_q <= y_d;
        if (frame_wrap) begin
          sof_q   <= 1'b1;
          frame_q <= frame_q + 16'd1;
        end
        dly_q[0] <= {act_raw, hs_raw, vs_raw};
        for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
        blank_q <= act_dly;
        hsync_q <= hs_dly ^ SyncInv;
        vsync_q <= vs_dly ^ SyncInv;
        rgb_q   <= act_dly ? rgb_in : 8'h00;
      end
    end
  end

  assign pixelX       = $signed(x_q);
  assign pixelY       = $signed(y_q);
  assign startOfFrame = sof_q;
  assign frame_count  = frame_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign blank_n      = blank_q;
  assign rgb_out      = rgb_q;

endmodule
